pipeline_flow_ctrl: RTL and testbench

Central stall/flush sequencer for the 16-bit pipelined processor. It combines the ID-stage `kill` from the control-hazard unit, the load-use hazard flag, halt requests and the data-memory wait handshake. From these it produces per-stage write enables, flush and bubble controls in one fixed priority order. It also keeps saturating stall and flush counters, and runs a drain-then-halt sequence and a memory-timeout error trap.

---
 rtl/pipeline_flow_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
// Stall/flush sequencer: fixed-priority per-stage enables, flush/bubble controls,
// saturating event counters, drain-then-halt sequencing and a memory-timeout trap.
module pipeline_flow_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int DRAIN       = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             kill,
  input  logic             load_use,
  input  logic             halt_req,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALT} state_e;

  localparam logic [7:0]       TMO      = 8'(MEM_TIMEOUT);
  localparam logic [2:0]       DRN_LAST = 3'(DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Control vector order: {pc, ifid, idex, exmem, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [6:0] CTL_NORM   = 7'b1111000;
  localparam logic [6:0] CTL_FREEZE = 7'b0000001;
  localparam logic [6:0] CTL_LDUSE  = 7'b0011010;
  localparam logic [6:0] CTL_KILL   = 7'b1111100;
  localparam logic [6:0] CTL_DRAIN  = 7'b0111100;

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic       mem_stall, freeze;
  logic       stall_ev, flush_ev;
  logic [7:0] wait_nxt;
  logic [6:0] ctl;

  assign mem_stall = mem_req & ~mem_ready;
  // Once waiting, only mem_ready releases the freeze; mem_req is already latched in MEM.
  assign freeze    = (state_q == S_MEM_WAIT) ? ~mem_ready : mem_stall;
  assign wait_nxt  = (state_q == S_RUN) ? 8'd1 : wait_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;
    ctl         = 7'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (freeze) begin
          ctl        = CTL_FREEZE;
          stall_ev   = 1'b1;
          wait_cnt_d = wait_nxt;
          if (wait_nxt >= TMO) begin
            mem_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            state_d   = S_MEM_WAIT;
          end
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = S_RUN;
          if (load_use) begin
            ctl      = CTL_LDUSE;
            stall_ev = 1'b1;
          end else if (kill) begin
            ctl      = CTL_KILL;
            flush_ev = 1'b1;
          end else begin
            ctl = CTL_NORM;
            if (halt_req) begin
              state_d     = S_DRAIN;
              drain_cnt_d = 3'd0;
            end
          end
        end
      end
      S_DRAIN: begin
        // ID is being flushed, so kill/load_use/halt_req carry no meaning here.
        if (mem_stall) begin
          ctl        = CTL_FREEZE;
          stall_ev   = 1'b1;
          wait_cnt_d = wait_nxt;
          if (wait_nxt >= TMO) begin
            mem_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end else begin
          ctl         = CTL_DRAIN;
          wait_cnt_d  = 8'd0;
          drain_cnt_d = drain_cnt_q + 3'd1;
          if (drain_cnt_q == DRN_LAST) state_d = S_HALT;
        end
      end
      S_HALT:  ctl = 7'b0;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 8'd0;
      drain_cnt_q <= 3'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
      if (stall_ev && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_ev && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  // Controls are forced quiet while reset is held, independent of the registers.
  assign {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble} =
         RESET_N ? ctl : 7'b0;

  assign halted      = (state_q == S_HALT);
  assign mem_err     = mem_err_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Randomized + directed bench for pipeline_flow_ctrl against a rule-level model;
// a second instance with CNT_W=4 exercises counter saturation.
module tb_pipeline_flow_ctrl;
  localparam int MT = 15;
  localparam int DR = 3;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic kill = 1'b0, load_use = 1'b0, halt_req = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble;
  logic halted, mem_err;
  logic [15:0] stall_count, flush_count;
  logic pc_we4, ifid_we4, idex_we4, exmem_we4, ifid_flush4, idex_bubble4, memwb_bubble4;
  logic halted4, mem_err4;
  logic [3:0] stall_count4, flush_count4;
  logic [6:0] ctl;

  assign ctl = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble};

  always #5 CLK = ~CLK;

  pipeline_flow_ctrl #(.CNT_W(16), .MEM_TIMEOUT(MT), .DRAIN(DR)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .kill(kill), .load_use(load_use), .halt_req(halt_req),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .idex_we(idex_we), .exmem_we(exmem_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble), .halted(halted),
    .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count));

  pipeline_flow_ctrl #(.CNT_W(4), .MEM_TIMEOUT(MT), .DRAIN(DR)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .kill(kill), .load_use(load_use), .halt_req(halt_req),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we4), .ifid_we(ifid_we4),
    .idex_we(idex_we4), .exmem_we(exmem_we4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .memwb_bubble(memwb_bubble4), .halted(halted4),
    .mem_err(mem_err4), .stall_count(stall_count4), .flush_count(flush_count4));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Rule-level model: which phase the core is in, plus event tallies as plain ints.
  typedef struct {
    bit waiting; bit draining; bit stopped; bit err;
    int waits; int drained; int stalls; int flushes;
  } mdl_t;
  mdl_t m;

  function automatic logic [6:0] exp_ctl(input mdl_t c, output bit st, output bit fl);
    st = 1'b0; fl = 1'b0;
    if (!RESET_N || c.stopped) return 7'b0;
    if (c.draining) begin
      if (mem_req && !mem_ready) begin st = 1'b1; return 7'b0000001; end
      return 7'b0111100;
    end
    if (c.waiting ? !mem_ready : (mem_req && !mem_ready)) begin st = 1'b1; return 7'b0000001; end
    if (load_use) begin st = 1'b1; return 7'b0011010; end
    if (kill) begin fl = 1'b1; return 7'b1111100; end
    return 7'b1111000;
  endfunction

  function automatic mdl_t m_next(input mdl_t c);
    mdl_t n;
    bit st, fl;
    n = c;
    void'(exp_ctl(c, st, fl));
    if (st) n.stalls++;
    if (fl) n.flushes++;
    if (c.stopped) return n;
    if (c.draining) begin
      if (mem_req && !mem_ready) begin
        n.waits++;
        if (n.waits >= MT) begin n.err = 1'b1; n.stopped = 1'b1; n.draining = 1'b0; end
      end else begin
        n.waits = 0;
        n.drained++;
        if (n.drained == DR) begin n.stopped = 1'b1; n.draining = 1'b0; end
      end
    end else if (c.waiting ? !mem_ready : (mem_req && !mem_ready)) begin
      n.waits++;
      n.waiting = 1'b1;
      if (n.waits >= MT) begin n.err = 1'b1; n.stopped = 1'b1; n.waiting = 1'b0; end
    end else begin
      n.waits = 0;
      n.waiting = 1'b0;
      if (!load_use && !kill && halt_req) begin n.draining = 1'b1; n.drained = 0; end
    end
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  always @(posedge CLK) begin
    if (!RESET_N) m <= '{default: 0};
    else          m <= m_next(m);
  end

  always @(negedge CLK) begin
    logic [6:0] e;
    bit st, fl;
    e = exp_ctl(m, st, fl);
    chk("ctl", {25'd0, ctl}, {25'd0, e});
    chk("halted", {31'd0, halted}, {31'd0, RESET_N && m.stopped});
    chk("mem_err", {31'd0, mem_err}, {31'd0, RESET_N && m.err});
    chk("stall_count", {16'd0, stall_count}, RESET_N ? sat(m.stalls, 16) : 0);
    chk("flush_count", {16'd0, flush_count}, RESET_N ? sat(m.flushes, 16) : 0);
    chk("stall_count4", {28'd0, stall_count4}, RESET_N ? sat(m.stalls, 4) : 0);
    chk("flush_count4", {28'd0, flush_count4}, RESET_N ? sat(m.flushes, 4) : 0);
  end

  // Inputs change just after the rising edge; checks follow at the falling edge.
  task automatic step(input bit rst, input bit lu, input bit k, input bit h,
                      input bit mr, input bit rdy);
    @(posedge CLK);
    #1;
    RESET_N = rst; load_use = lu; kill = k; halt_req = h; mem_req = mr; mem_ready = rdy;
    @(negedge CLK);
  endtask

  function automatic bit rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  initial begin
    @(negedge CLK);
    chk("rst_ctl", {25'd0, ctl}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    step(1, 0, 0, 0, 0, 0);
    chk("idle_ctl", {25'd0, ctl}, 32'b1111000);
    chk("idle_stall", {16'd0, stall_count}, 32'd0);

    step(1, 1, 1, 0, 0, 0);
    chk("lu_kill_ctl", {25'd0, ctl}, 32'b0011010);
    step(1, 0, 1, 0, 0, 0);
    chk("kill_ctl", {25'd0, ctl}, 32'b1111100);
    chk("lu_stall_cnt", {16'd0, stall_count}, 32'd1);
    chk("lu_no_flush", {16'd0, flush_count}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("kill_flush_cnt", {16'd0, flush_count}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("mw_freeze", {25'd0, ctl}, 32'b0000001);
    end
    step(1, 0, 0, 0, 1, 1);
    chk("mw_release", {25'd0, ctl}, 32'b1111000);
    chk("mw_stall_cnt", {16'd0, stall_count}, 32'd5);

    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("tmo_not_halted", {31'd0, halted}, 32'd0);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("tmo_halted", {31'd0, halted}, 32'd1);
    chk("tmo_mem_err", {31'd0, mem_err}, 32'd1);
    chk("tmo_ctl", {25'd0, ctl}, 32'd0);
    chk("tmo_stall_cnt", {16'd0, stall_count}, 32'd15);

    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    chk("late_ready_ctl", {25'd0, ctl}, 32'b1111000);
    step(1, 0, 0, 0, 0, 0);
    chk("late_ready_err", {31'd0, mem_err}, 32'd0);
    chk("late_ready_halted", {31'd0, halted}, 32'd0);

    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("halt_req_ctl", {25'd0, ctl}, 32'b1111000);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("drain_ctl", {25'd0, ctl}, 32'b0111100);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("drain_halted", {31'd0, halted}, 32'd1);

    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("dstall_d1", {25'd0, ctl}, 32'b0111100);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("dstall_freeze", {25'd0, ctl}, 32'b0000001);
    end
    step(1, 0, 0, 0, 1, 1);
    chk("dstall_d2", {25'd0, ctl}, 32'b0111100);
    step(1, 0, 0, 0, 0, 0);
    chk("dstall_d3", {25'd0, ctl}, 32'b0111100);
    chk("dstall_not_halted", {31'd0, halted}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("dstall_halted", {31'd0, halted}, 32'd1);
    chk("dstall_cnt", {16'd0, stall_count}, 32'd3);

    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_drain_ctl", {25'd0, ctl}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("post_rst_ctl", {25'd0, ctl}, 32'b1111000);
    chk("post_rst_halted", {31'd0, halted}, 32'd0);

    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("sat_flush4", {28'd0, flush_count4}, 32'd15);
    chk("sat_flush16", {16'd0, flush_count}, 32'd19);

    for (int ep = 0; ep < 40; ep++) begin
      int rdy_pct, mem_pct;
      rdy_pct = (ep % 4 == 0) ? 3 : ((ep % 4 == 1) ? 50 : 85);
      mem_pct = 20 + 20 * (ep % 3);
      step(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 60; c++)
        step($urandom_range(149) != 0, rnd(20), rnd(25), rnd(3), rnd(mem_pct), rnd(rdy_pct));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
